pipe_skid_reg: RTL and testbench
================================

Name: pipe_skid_reg

Overview:
- Elastic two-entry pipeline stage register with valid/ready handshake on both sides. It sits between CPU pipeline stages, for example IF/ID and ID/EX.
- It absorbs one cycle of downstream backpressure without losing data.
- in_ready is registered and never depends combinationally on out_ready, which breaks the stall timing path.
- Supports a synchronous flush for branch mispredicts.

Parameters:
- WIDTH, 64, payload width in bits.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- flush  input  1  synchronous flush; clears both entries at the next edge.
- in_valid  input  1  upstream has a payload this cycle.
- in_ready  output  1  block can accept a payload this cycle (registered).
- in_data  input  WIDTH  upstream payload.
- out_valid  output  1  out_data holds a valid payload.
- out_ready  input  1  downstream accepts the payload this cycle.
- out_data  output  WIDTH  payload to downstream (registered).
- occupancy  output  2  number of held entries (0..2).

Behaviour:
- Definitions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready. All state updates occur on the rising clk edge, except reset.
- Reset (reset=0, asynchronous, any time including mid-transfer):
  - State EMPTY, main and skid data cleared to 0.
  - out_valid=0, out_data=0, in_ready=1, occupancy=0.
  - Any payload held at the moment of reset is discarded.
- Storage: main entry drives out_data/out_valid; skid entry is internal.
- States:
  - EMPTY: occupancy 0, out_valid 0, in_ready 1.
  - ONE: occupancy 1, out_valid 1, in_ready 1.
  - FULL: occupancy 2, out_valid 1, in_ready 0.
- Transitions when flush=0:
  - EMPTY, in_fire: main<=in_data, go to ONE.
  - EMPTY, no fire: stay in EMPTY.
  - ONE, in_fire & out_fire: main<=in_data, stay in ONE.
  - ONE, in_fire & !out_ready: skid<=in_data, go to FULL.
  - ONE, !in_fire & out_fire: go to EMPTY. out_data holds its stale value; the bench must not check it.
  - ONE, no fire: hold.
  - FULL, out_fire: main<=skid, go to ONE.
  - FULL, no fire: hold. in_valid is ignored because in_ready=0.
- Flush:
  - flush=1 at an edge forces EMPTY and clears main and skid to 0, overriding any simultaneous in_fire or out_fire.
  - A payload offered with flush=1 is dropped, even though in_ready may read 1 that cycle.
  - A downstream out_fire in the same cycle as flush is still a legal transfer of the current out_data.
- Ordering and throughput:
  - Latency is 1 cycle from in_fire to out_valid when EMPTY.
  - Sustained throughput is 1 payload per cycle when out_ready stays high.
  - Order is strict FIFO; no payload is duplicated or dropped except by reset or flush.
- Timing: in_ready is driven from state register bits only.

Decomposition:
- Package pipe_pkg:
  - typedef enum logic [1:0] pipe_state_t {EMPTY=0, ONE=1, FULL=2}. Encoding 3 is illegal and recovers to EMPTY.
  - Constant WORD_W=64.
- Sub-module pipe_data_reg:
  - Parameter WIDTH.
  - Ports: clk, reset (async active-low clear), clr (sync clear), en (load enable), d, q.
  - Instantiated twice, once for main and once for skid.
- The top level holds the state FSM and the next-state/load-select logic.

Test Plan:
1. Reset release, then in_valid=1, in_data=64'hA5, out_ready=1 -> next cycle out_valid=1, out_data=64'hA5, occupancy=1, in_ready=1.
2. Stream 64'h1, 64'h2, 64'h3 on consecutive cycles with out_ready=1 -> out_data shows 1, 2, 3 on consecutive cycles; in_ready stays 1.
3. Hold out_ready=0 and offer 64'h10 then 64'h11 -> occupancy=2, in_ready=0, 64'h12 held off. Raise out_ready -> outputs 10, 11, 12 in order, none lost.
4. In FULL with out_ready=0, assert flush with in_valid=1, in_data=64'hFF -> next cycle occupancy=0, out_valid=0, out_data=0, in_ready=1; 64'hFF never appears at the output.
5. In FULL, drive reset=0 asynchronously mid-cycle -> out_valid=0, in_ready=1, occupancy=0 immediately, before the next edge. After release, 64'h7 passes through normally.

Source files
------------

// File: rtl/pipe_skid_reg_pkg.sv
// Shared types for the elastic pipeline stage register.
// State encoding and payload width used by the skid register and its bus.
package pipe_pkg;

  localparam int WORD_W = 64;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } pipe_state_t;

  function automatic logic [1:0] occ_of(pipe_state_t s);
    logic [1:0] o;
    o = 2'd0;
    case (s)
      ONE:     o = 2'd1;
      FULL:    o = 2'd2;
      default: o = 2'd0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/pipe_skid_reg_if.sv
// Valid/ready bus for the skid register: upstream and downstream sides.
// The master drives payloads and out_ready; the slave is the stage.
interface pipe_skid_reg_if #(
  parameter int WIDTH = pipe_pkg::WORD_W
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       occupancy;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  occupancy
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output occupancy
  );

endinterface

// File: rtl/pipe_data_reg.sv
// Payload register with async reset, sync clear and load enable.
// Used for both the main (output) and skid entries.
module pipe_data_reg #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_skid_reg.sv
// Two-entry elastic stage register with registered in_ready and flush.
// Main entry feeds the output; skid entry catches one stalled payload.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int WIDTH = WORD_W
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           flush,
  pipe_skid_reg_if.slave bus
);

  pipe_state_t      state_q;
  pipe_state_t      state_d;
  logic             in_fire;
  logic             out_fire;
  logic             main_en;
  logic             skid_en;
  logic             main_from_skid;
  logic [WIDTH-1:0] main_d;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;

  // Handshake outputs decode straight from the state register.
  assign bus.in_ready  = (state_q == EMPTY) || (state_q == ONE);
  assign bus.out_valid = (state_q == ONE) || (state_q == FULL);
  assign bus.occupancy = occ_of(state_q);
  assign bus.out_data  = main_q;

  assign in_fire  = bus.in_valid & bus.in_ready;
  assign out_fire = bus.out_valid & bus.out_ready;
  assign main_d   = main_from_skid ? skid_q : bus.in_data;

  always_comb begin
    state_d        = state_q;
    main_en        = 1'b0;
    skid_en        = 1'b0;
    main_from_skid = 1'b0;
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          main_en = 1'b1;
          state_d = ONE;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          main_en = 1'b1;
        end else if (in_fire) begin
          skid_en = 1'b1;
          state_d = FULL;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_fire) begin
          main_en        = 1'b1;
          main_from_skid = 1'b1;
          state_d        = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (flush) begin
      state_d = EMPTY;
      main_en = 1'b0;
      skid_en = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  pipe_data_reg #(.WIDTH(WIDTH)) u_main (
    .clk   (clk),
    .reset (reset),
    .clr   (flush),
    .en    (main_en),
    .d     (main_d),
    .q     (main_q)
  );

  pipe_data_reg #(.WIDTH(WIDTH)) u_skid (
    .clk   (clk),
    .reset (reset),
    .clr   (flush),
    .en    (skid_en),
    .d     (bus.in_data),
    .q     (skid_q)
  );

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Scoreboard bench for pipe_skid_reg: FIFO reference model, directed + random.
module tb_pipe_skid_reg;

  logic clk;
  logic rst_n;
  logic flush;

  logic [63:0] exp_q[$];
  logic        acc_ok;
  logic        zero_exp;
  int          n_chk;
  int          n_fail;
  int          sz;

  pipe_skid_reg_if #(.WIDTH(64)) bus ();

  pipe_skid_reg #(.WIDTH(64)) dut (
    .clk   (clk),
    .reset (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: compare DUT against the FIFO model, then retire on out_fire.
  always @(negedge clk) begin
    sz = exp_q.size();
    chk("occupancy", {62'd0, bus.occupancy}, 64'(sz));
    chk("out_valid", {63'd0, bus.out_valid}, {63'd0, sz > 0});
    chk("in_ready", {63'd0, bus.in_ready}, {63'd0, sz < 2});
    if (sz > 0) chk("out_data", bus.out_data, exp_q[0]);
    else if (zero_exp) chk("out_data_zero", bus.out_data, 64'd0);
    acc_ok = rst_n && (sz < 2) && !flush;
    if (rst_n) begin
      if (flush) begin
        exp_q.delete();
        zero_exp = 1'b1;
      end else if (sz > 0 && bus.out_ready) begin
        void'(exp_q.pop_front());
        zero_exp = 1'b0;
      end
    end
  end

  // Stimulus: accepted payloads are pushed as future expected outputs.
  task automatic drive(input logic v, input logic [63:0] d,
                       input logic ordy, input logic fl);
    @(posedge clk);
    #1;
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = ordy;
    flush         = fl;
    @(negedge clk);
    #1;
    if (v && acc_ok) exp_q.push_back(d);
  endtask

  initial begin
    n_chk         = 0;
    n_fail        = 0;
    acc_ok        = 1'b0;
    zero_exp      = 1'b1;
    rst_n         = 1'b0;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // 1: single payload, one-cycle latency
    drive(1'b1, 64'hA5, 1'b1, 1'b0);
    drive(1'b0, 64'h0, 1'b0, 1'b0);
    drive(1'b0, 64'h0, 1'b1, 1'b0);

    // 2: back-to-back stream
    drive(1'b1, 64'h1, 1'b1, 1'b0);
    drive(1'b1, 64'h2, 1'b1, 1'b0);
    drive(1'b1, 64'h3, 1'b1, 1'b0);
    drive(1'b0, 64'h0, 1'b1, 1'b0);
    drive(1'b0, 64'h0, 1'b1, 1'b0);

    // 3: backpressure fills both entries, then drains in order
    drive(1'b1, 64'h10, 1'b0, 1'b0);
    drive(1'b1, 64'h11, 1'b0, 1'b0);
    drive(1'b1, 64'h12, 1'b0, 1'b0);
    drive(1'b1, 64'h12, 1'b1, 1'b0);
    drive(1'b1, 64'h12, 1'b1, 1'b0);
    drive(1'b0, 64'h0, 1'b1, 1'b0);
    drive(1'b0, 64'h0, 1'b1, 1'b0);

    // 4: flush while full drops the offered payload
    drive(1'b1, 64'h20, 1'b0, 1'b0);
    drive(1'b1, 64'h21, 1'b0, 1'b0);
    drive(1'b1, 64'hFF, 1'b0, 1'b1);
    drive(1'b0, 64'h0, 1'b0, 1'b0);
    drive(1'b0, 64'h0, 1'b1, 1'b0);

    // 5: async reset mid-cycle while full
    drive(1'b1, 64'h30, 1'b0, 1'b0);
    drive(1'b1, 64'h31, 1'b0, 1'b0);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
    chk("rst_occupancy", {62'd0, bus.occupancy}, 64'd0);
    chk("rst_out_data", bus.out_data, 64'd0);
    exp_q.delete();
    zero_exp = 1'b1;
    drive(1'b0, 64'h0, 1'b0, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    drive(1'b1, 64'h7, 1'b1, 1'b0);
    drive(1'b0, 64'h0, 1'b1, 1'b0);
    drive(1'b0, 64'h0, 1'b1, 1'b0);

    // Random traffic with occasional flushes
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(9) < 7, {$urandom, $urandom},
            $urandom_range(9) < 6, $urandom_range(39) == 0);
    end
    for (int i = 0; i < 4; i++) drive(1'b0, 64'h0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, expected finish");
    $fatal(1, "timeout");
  end

endmodule
